ula_multiciclo: RTL
===================

Name: ula_multiciclo

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Executes every existing single-cycle ALU op with one-cycle registered latency.
- Adds multi-cycle signed/unsigned multiply and divide writing HI/LO, and a signed-overflow flag.
- Sits in the EX stage. The control unit stalls on busy and samples result/HI/LO on done.

Parameters:
- WIDTH, 32, operand/result width (even, >= 8).
- SHW, 5, shift-amount width (clog2(WIDTH)); shifts use In1[SHW-1:0].

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  request strobe; sampled only when busy=0
- In1  input  WIDTH  operand A (shift amount for shift ops)
- In2  input  WIDTH  operand B (value shifted for shift ops)
- OP  input  5  opcode. Existing ula_opcodes.vh codes zero-extended. New codes: `MULT=5'h10, `MULTU=5'h11, `DIV=5'h12, `DIVU=5'h13.
- result  output  WIDTH  registered result
- Zero_Flag  output  1  registered (result==0)
- Overflow  output  1  signed overflow of ADD/SUB, else 0
- HI  output  WIDTH  mult high word / div remainder
- LO  output  WIDTH  mult low word / div quotient
- busy  output  1  multi-cycle op in progress
- done  output  1  one-cycle pulse: outputs valid

Behaviour:
- Reset (async, reset_n=0): FSM->IDLE; result, HI, LO, Overflow, busy, done = 0; Zero_Flag = 1. Any in-flight op is aborted with no partial HI/LO update.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE + start + single-cycle OP: on the same edge, register result/Zero_Flag/Overflow and assert done for 1 cycle. Latency is 1.
  - Semantics equal the combinational ALU: ADD, SUB, AND, OR, XOR, NOR, SLT, SLTU, SLL/SRL/SRA(V) by In1[SHW-1:0], JR passes In1.
  - Undefined OP gives result=0.
- IDLE + start + MULT/MULTU: latch operands and go to MUL; busy=1.
  - For signed ops, latch magnitudes and record the result sign (sign_q = sA^sB; sign_r = sA).
- MUL: one shift-add iteration per cycle, WIDTH iterations, then FIX.
- DIV: one restoring-division step per cycle, WIDTH iterations, then FIX.
- FIX (1 cycle): apply sign correction, then write HI/LO.
  - result = LO; Zero_Flag from LO; Overflow = 0.
  - busy->0, done=1, back to IDLE.
  - Total latency from the start edge to the done edge is WIDTH+2 cycles.
- Signed division: quotient sign = sA^sB; remainder sign = dividend sign (truncating division).
- Divide by zero (In2==0, DIV or DIVU): no iterations; go directly to FIX with HI=In1, LO={WIDTH{1'b1}}. Latency is 2.
- Most-negative / -1 under DIV: HI=0, LO=most-negative value (natural wrap), no flag.
- Overflow: ADD sets it when operand signs match and result sign differs. SUB sets it when operand signs differ and result sign differs from In1. Other ops give 0.
- start while busy=1 is ignored. The latched operands and OP are unaffected by input changes during busy.
- Start in the same cycle done is high is accepted (back-to-back).
- HI/LO change only at FIX. Single-cycle ops never alter them.
- result, Zero_Flag and Overflow hold their value between operations.
- done is never high while busy is high, except in FIX, where busy is already 0.

Test Plan:
- Reset mid-MUL: start `MULT, then reset_n=0 at cycle 5 -> all outputs 0, Zero_Flag=1, busy=0 immediately, HI/LO stay 0 after release.
- ADD: In1=32'h7FFFFFFF, In2=1 -> next edge result=32'h80000000, Overflow=1, done=1 for 1 cycle. SUB 5-5 -> result=0, Zero_Flag=1, Overflow=0.
- MULT: In1=-3, In2=7 -> done exactly 34 cycles after start; HI=32'hFFFFFFFF, LO=32'hFFFFFFEB; MULTU 32'hFFFFFFFF*2 -> HI=1, LO=32'hFFFFFFFE.
- DIV: In1=-7, In2=2 -> LO=32'hFFFFFFFD (-3), HI=32'hFFFFFFFF (-1). DIVU 100/7 -> LO=14, HI=2.
- Divide by zero: DIVU In1=9, In2=0 -> done 2 cycles after start; HI=9, LO=32'hFFFFFFFF. Second start during busy ignored (HI/LO unchanged).
- Back-to-back: SLL In1=4, In2=1 issued in the done cycle of a MULTU -> result=16 one cycle later, HI/LO retain the MULTU values.

Source files
------------

// File: rtl/ula_multiciclo.sv
// rtl/ula_multiciclo.sv - registered ALU with multi-cycle shift-add multiply and restoring divide
module ula_multiciclo #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] In1,
    input  logic [WIDTH-1:0] In2,
    input  logic [4:0]       OP,
    output logic [WIDTH-1:0] result,
    output logic             Zero_Flag,
    output logic             Overflow,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             done
);
    localparam logic [4:0] OP_ADD   = 5'h00;
    localparam logic [4:0] OP_SUB   = 5'h01;
    localparam logic [4:0] OP_AND   = 5'h02;
    localparam logic [4:0] OP_OR    = 5'h03;
    localparam logic [4:0] OP_XOR   = 5'h04;
    localparam logic [4:0] OP_NOR   = 5'h05;
    localparam logic [4:0] OP_SLT   = 5'h06;
    localparam logic [4:0] OP_SLTU  = 5'h07;
    localparam logic [4:0] OP_SLL   = 5'h08;
    localparam logic [4:0] OP_SRL   = 5'h09;
    localparam logic [4:0] OP_SRA   = 5'h0A;
    localparam logic [4:0] OP_JR    = 5'h0B;
    localparam logic [4:0] OP_SLLV  = 5'h0C;
    localparam logic [4:0] OP_SRLV  = 5'h0D;
    localparam logic [4:0] OP_SRAV  = 5'h0E;
    localparam logic [4:0] OP_MULT  = 5'h10;
    localparam logic [4:0] OP_MULTU = 5'h11;
    localparam logic [4:0] OP_DIV   = 5'h12;
    localparam logic [4:0] OP_DIVU  = 5'h13;

    localparam logic [SHW:0] CNT_LAST = (SHW+1)'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [SHW:0]     cnt_q, cnt_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;
    logic             is_mul_q, is_mul_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] alu_sum, alu_diff, alu_res;
    logic             alu_ovf, alu_single;

    always_comb begin
        shamt      = In1[SHW-1:0];
        alu_sum    = In1 + In2;
        alu_diff   = In1 - In2;
        alu_res    = '0;
        alu_ovf    = 1'b0;
        alu_single = 1'b1;
        case (OP)
            OP_ADD: begin
                alu_res = alu_sum;
                alu_ovf = (In1[WIDTH-1] == In2[WIDTH-1]) && (alu_sum[WIDTH-1] != In1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = alu_diff;
                alu_ovf = (In1[WIDTH-1] != In2[WIDTH-1]) && (alu_diff[WIDTH-1] != In1[WIDTH-1]);
            end
            OP_AND:           alu_res = In1 & In2;
            OP_OR:            alu_res = In1 | In2;
            OP_XOR:           alu_res = In1 ^ In2;
            OP_NOR:           alu_res = ~(In1 | In2);
            OP_SLT:           alu_res = {{(WIDTH-1){1'b0}}, $signed(In1) < $signed(In2)};
            OP_SLTU:          alu_res = {{(WIDTH-1){1'b0}}, In1 < In2};
            OP_SLL, OP_SLLV:  alu_res = In2 << shamt;
            OP_SRL, OP_SRLV:  alu_res = In2 >> shamt;
            OP_SRA, OP_SRAV:  alu_res = $signed(In2) >>> shamt;
            OP_JR:            alu_res = In1;
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_single = 1'b0;
            default:          alu_res = '0;
        endcase
    end

    // Signed mult/div run on magnitudes; the signs are reapplied in FIX.
    logic             op_signed, neg_a, neg_b;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        op_signed = (OP == OP_MULT) || (OP == OP_DIV);
        neg_a     = op_signed & In1[WIDTH-1];
        neg_b     = op_signed & In2[WIDTH-1];
        mag_a     = neg_a ? -In1 : In1;
        mag_b     = neg_b ? -In2 : In2;
    end

    logic [WIDTH:0]     mul_sum, div_r, div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        div_r    = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_diff = div_r - {1'b0, opb_q};
        div_ge   = ~div_diff[WIDTH];
        prod_neg = -{acc_hi_q, acc_lo_q};
    end

    logic [WIDTH-1:0] fix_hi, fix_lo;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        acc_hi_d  = acc_hi_q;
        acc_lo_d  = acc_lo_q;
        opb_d     = opb_q;
        cnt_d     = cnt_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        is_mul_d  = is_mul_q;
        fix_hi    = '0;
        fix_lo    = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (alu_single) begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        ovf_d    = alu_ovf;
                        done_d   = 1'b1;
                    end else begin
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        quo_neg_d = neg_a ^ neg_b;
                        rem_neg_d = neg_a;
                        acc_hi_d  = '0;
                        if (OP == OP_MULT || OP == OP_MULTU) begin
                            is_mul_d = 1'b1;
                            acc_lo_d = mag_b;
                            opb_d    = mag_a;
                            state_d  = S_MUL;
                        end else if (In2 == '0) begin
                            // Divide by zero skips iterating and presents the raw dividend.
                            is_mul_d  = 1'b0;
                            acc_hi_d  = In1;
                            acc_lo_d  = '1;
                            quo_neg_d = 1'b0;
                            rem_neg_d = 1'b0;
                            state_d   = S_FIX;
                        end else begin
                            is_mul_d = 1'b0;
                            acc_lo_d = mag_a;
                            opb_d    = mag_b;
                            state_d  = S_DIV;
                        end
                    end
                end
            end
            S_MUL: begin
                acc_hi_d = mul_sum[WIDTH:1];
                acc_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_DIV: begin
                acc_hi_d = div_ge ? div_diff[WIDTH-1:0] : div_r[WIDTH-1:0];
                acc_lo_d = {acc_lo_q[WIDTH-2:0], div_ge};
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_mul_q) begin
                    {fix_hi, fix_lo} = quo_neg_q ? prod_neg : {acc_hi_q, acc_lo_q};
                end else begin
                    fix_hi = rem_neg_q ? -acc_hi_q : acc_hi_q;
                    fix_lo = quo_neg_q ? -acc_lo_q : acc_lo_q;
                end
                hi_d     = fix_hi;
                lo_d     = fix_lo;
                result_d = fix_lo;
                zero_d   = (fix_lo == '0);
                ovf_d    = 1'b0;
                busy_d   = 1'b0;
                done_d   = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b1;
            ovf_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            acc_hi_q  <= '0;
            acc_lo_q  <= '0;
            opb_q     <= '0;
            cnt_q     <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            is_mul_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            acc_hi_q  <= acc_hi_d;
            acc_lo_q  <= acc_lo_d;
            opb_q     <= opb_d;
            cnt_q     <= cnt_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            is_mul_q  <= is_mul_d;
        end
    end

    assign result    = result_q;
    assign Zero_Flag = zero_q;
    assign Overflow  = ovf_q;
    assign HI        = hi_q;
    assign LO        = lo_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
